serial_adder32: RTL and testbench

//   Digit-serial adder: the addition counterpart of the team's 32-bit subtractor.

---
 rtl/serial_adder32_if.sv | 37 +++
 rtl/serial_adder32.sv | 122 ++++++++++++
 tb/tb_serial_adder32.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/serial_adder32_if.sv
// Handshake/data bundle for the digit-serial adder.
// The ovf signal exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_adder32_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b, carry_in,
    input  busy, done, sum, carry_out, ovf
  );

  modport slave (
    input  start, a, b, carry_in,
    output busy, done, sum, carry_out, ovf
  );
`else
  modport master (
    output start, a, b, carry_in,
    input  busy, done, sum, carry_out
  );

  modport slave (
    input  start, a, b, carry_in,
    output busy, done, sum, carry_out
  );
`endif
endinterface

// File: rtl/serial_adder32.sv
// Digit-serial adder: a + b + carry_in computed DIGIT bits per cycle, LSB first,
// over WIDTH/DIGIT cycles with a start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start; sum/carry_out hold the last completed result
// RUN   | one digit added per edge; completes on the edge where cnt == N-1
module serial_adder32 #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_adder32_if.slave  bus
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] s_r;
  logic             c_r;
  logic [CNT_W-1:0] cnt;

  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;

  logic [DIGIT:0]   dig_sum;
  logic [WIDTH-1:0] s_next;

`ifdef SERIAL_ADD_OVF_EN
  // Operand sign bits are kept separately because a_r/b_r are shifted away.
  logic a_msb;
  logic b_msb;
  logic ovf_r;
`endif

  // One digit slice of the addition and the partial sum after shifting it in at the MSB end.
  always_comb begin
    dig_sum = '0;
    s_next  = '0;
    dig_sum = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_r};
    s_next  = {dig_sum[DIGIT-1:0], s_r[WIDTH-1:DIGIT]};
  end

  // Control FSM, datapath shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      s_r    <= '0;
      c_r    <= 1'b0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      sum_r  <= '0;
      cout_r <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf_r  <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_r    <= bus.a;
            b_r    <= bus.b;
            c_r    <= bus.carry_in;
            s_r    <= '0;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
`ifdef SERIAL_ADD_OVF_EN
            a_msb  <= bus.a[WIDTH-1];
            b_msb  <= bus.b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          a_r <= a_r >> DIGIT;
          b_r <= b_r >> DIGIT;
          s_r <= s_next;
          c_r <= dig_sum[DIGIT];
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            sum_r  <= s_next;
            cout_r <= dig_sum[DIGIT];
            done_r <= 1'b1;
            busy_r <= 1'b0;
            state  <= IDLE;
`ifdef SERIAL_ADD_OVF_EN
            ovf_r  <= (a_msb == b_msb) && (s_next[WIDTH-1] != a_msb);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.sum       = sum_r;
  assign bus.carry_out = cout_r;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_serial_adder32.sv
// Directed bench for serial_adder32: expected results are queued when a
// request is issued and compared when done pulses.
module tb_serial_adder32;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_adder32_if #(.WIDTH(W)) bus ();

  serial_adder32 #(.WIDTH(W), .DIGIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    exp_t         e;
    logic [W:0]   t;
    t      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    e.sum  = t[W-1:0];
    e.cout = t[W];
    e.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    return e;
  endfunction

  // Called at a negedge; leaves the bench at the negedge after the accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input bit push);
    bus.start    = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.carry_in = cin;
    if (push) sb.push_back(model(a, b, cin));
    @(negedge clk);
    bus.start    = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.carry_in = 1'($urandom_range(0, 1));
    check("busy_after_start", W'(bus.busy), W'(1));
    check("done_after_start", W'(bus.done), W'(0));
  endtask

  // Waits (bounded) for done, checks latency in negedges, pops and compares.
  task automatic wait_done(input string tag, input int exp_k);
    int   k;
    exp_t e;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.done && k < 20);
    check({tag, "_latency"}, W'(k), W'(exp_k));
    check({tag, "_busy_at_done"}, W'(bus.busy), W'(0));
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, W'(0), W'(1));
    end else begin
      e = sb.pop_front();
      check({tag, "_sum"}, bus.sum, e.sum);
      check({tag, "_cout"}, W'(bus.carry_out), W'(e.cout));
`ifdef SERIAL_ADD_OVF_EN
      check({tag, "_ovf"}, W'(bus.ovf), W'(e.ovf));
`endif
    end
  endtask

  task automatic expect_no_done(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check(tag, W'(bus.done), W'(0));
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.carry_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", W'(bus.busy), W'(0));
    check("rst_done", W'(bus.done), W'(0));
    check("rst_sum", bus.sum, W'(0));
    check("rst_cout", W'(bus.carry_out), W'(0));
`ifdef SERIAL_ADD_OVF_EN
    check("rst_ovf", W'(bus.ovf), W'(0));
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic add, busy for the whole run
    start_op(32'd1200, 32'd1100, 1'b0, 1'b1);
    wait_done("t1", 8);
    @(negedge clk);
    check("t1_done_pulse", W'(bus.done), W'(0));
    check("t1_sum_hold", bus.sum, W'(2300));

    // 2: full wrap with carry out
    start_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
    wait_done("t2", 8);

    // 3: carry_in only, then back-to-back start in the done cycle
    @(negedge clk);
    start_op(32'd0, 32'd0, 1'b1, 1'b1);
    wait_done("t3a", 8);
    start_op(32'd16, 32'd1, 1'b0, 1'b1);
    wait_done("t3b", 8);

    // 4: start while busy is ignored
    @(negedge clk);
    start_op(32'd5, 32'd3, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'd100;
    bus.b     = 32'd100;
    @(negedge clk);
    bus.start = 1'b0;
    check("t4_busy_mid", W'(bus.busy), W'(1));
    wait_done("t4", 5);
    expect_no_done("t4_no_extra_done", 12);

    // 5: reset mid-operation aborts with no done
    start_op(32'd7, 32'd9, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", W'(bus.busy), W'(0));
    check("t5_rst_done", W'(bus.done), W'(0));
    check("t5_rst_sum", bus.sum, W'(0));
    check("t5_rst_cout", W'(bus.carry_out), W'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    expect_no_done("t5_no_done_after_abort", 10);
    check("t5_sum_still_zero", bus.sum, W'(0));
    start_op(32'd7, 32'd9, 1'b0, 1'b1);
    wait_done("t5", 8);

    // 6: signed overflow cases (ovf compared only when the feature is built)
    @(negedge clk);
    start_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1);
    wait_done("t6a", 8);
    @(negedge clk);
    start_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
    wait_done("t6b", 8);

    // a few random operands, with back-to-back issue on alternate rounds
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) @(negedge clk);
      start_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
      wait_done("rnd", 8);
    end

    @(negedge clk);
    check("sb_empty", W'(sb.size()), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
